seq_mem_pipe: RTL and testbench

SEQ_MEM_PIPE -- requirements
Module: seq_mem_pipe

---
 rtl/seq_mem_pkg.sv | 11 +
 rtl/seq_mem_rd_pipe.sv | 48 ++++
 rtl/seq_mem_pipe.sv | 150 +++++++++++++++
 tb/tb_seq_mem_pipe.sv | 294 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/seq_mem_pkg.sv
// Shared types and limits for the sequential memory with pipelined reads.
package seq_mem_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    CLEAR = 1'b1
  } state_t;

  localparam int MAX_READ_LATENCY = 4;

endpackage

// File: rtl/seq_mem_rd_pipe.sv
// Valid/data delay line of LATENCY stages; each stage keeps its data when no
// valid enters, so the last stage holds the most recent completed read.
module seq_mem_rd_pipe #(
  parameter int WIDTH   = 32,
  parameter int LATENCY = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data
);

  genvar gi;
  generate
    for (gi = 0; gi < LATENCY; gi++) begin : g_stage
      logic             valid_reg;
      logic [WIDTH-1:0] data_reg;
      logic             src_valid;
      logic [WIDTH-1:0] src_data;

      if (gi == 0) begin : g_head
        assign src_valid = in_valid;
        assign src_data  = in_data;
      end else begin : g_tail
        assign src_valid = g_stage[gi-1].valid_reg;
        assign src_data  = g_stage[gi-1].data_reg;
      end

      always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
          valid_reg <= 1'b0;
          data_reg  <= '0;
        end else begin
          valid_reg <= src_valid;
          if (src_valid) begin
            data_reg <= src_data;
          end
        end
      end
    end
  endgenerate

  assign out_valid = g_stage[LATENCY-1].valid_reg;
  assign out_data  = g_stage[LATENCY-1].data_reg;

endmodule

// File: rtl/seq_mem_pipe.sv
// Byte-maskable word memory with pipelined reads, single-request arbitration,
// and a one-word-per-cycle clear sweep with a sticky error flag.
module seq_mem_pipe
  import seq_mem_pkg::*;
#(
  parameter int WIDTH        = 32,
  parameter int SIZE         = 16,
  parameter int IDX_SIZE     = 4,
  parameter int READ_LATENCY = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [IDX_SIZE-1:0]   addr0,
  input  logic                  read_en,
  output logic [WIDTH-1:0]      out,
  output logic                  read_done,
  input  logic [WIDTH-1:0]      in,
  input  logic                  write_en,
  input  logic [WIDTH/8-1:0]    write_mask,
  output logic                  write_done,
  input  logic                  clear_en,
  output logic                  busy,
  output logic                  clear_done,
  output logic                  error
);

  localparam int NBYTES = WIDTH / 8;
  localparam int AW     = (SIZE > 1) ? $clog2(SIZE) : 1;
  localparam logic [IDX_SIZE-1:0] LAST_IDX = IDX_SIZE'(SIZE - 1);

  if (WIDTH % 8 != 0) begin : g_bad_width
    $error("seq_mem_pipe: WIDTH must be a multiple of 8");
  end
  if (READ_LATENCY < 1 || READ_LATENCY > MAX_READ_LATENCY) begin : g_bad_latency
    $error("seq_mem_pipe: READ_LATENCY must be within 1..MAX_READ_LATENCY");
  end
  if ((2 ** IDX_SIZE) < SIZE) begin : g_bad_idx
    $error("seq_mem_pipe: IDX_SIZE too narrow for SIZE");
  end

  state_t                state_reg, state_next;
  logic [IDX_SIZE-1:0]   clr_cnt_reg, clr_cnt_next;
  logic                  write_done_reg, write_done_next;
  logic                  clear_done_reg, clear_done_next;
  logic                  error_reg, error_next;
  logic                  acc_read, acc_write;
  logic                  in_range;
  logic [1:0]            req_cnt;
  logic [AW-1:0]         addr_idx, clr_idx;
  logic [WIDTH-1:0]      rd_data;
  wire  [WIDTH-1:0]      rd_word;

  assign req_cnt  = 2'(read_en) + 2'(write_en) + 2'(clear_en);
  assign in_range = (32'(addr0) < 32'(SIZE));
  assign addr_idx = addr0[AW-1:0];
  assign clr_idx  = clr_cnt_reg[AW-1:0];

  always_comb begin
    state_next      = state_reg;
    clr_cnt_next    = clr_cnt_reg;
    write_done_next = 1'b0;
    clear_done_next = 1'b0;
    error_next      = error_reg;
    acc_read        = 1'b0;
    acc_write       = 1'b0;
    case (state_reg)
      IDLE: begin
        if (req_cnt > 2'd1) begin
          error_next = 1'b1;
        end else if (read_en) begin
          acc_read = 1'b1;
          if (!in_range) error_next = 1'b1;
        end else if (write_en) begin
          // Out-of-range writes are dropped but still acknowledged.
          acc_write       = in_range;
          write_done_next = 1'b1;
          if (!in_range) error_next = 1'b1;
        end else if (clear_en) begin
          state_next   = CLEAR;
          clr_cnt_next = '0;
        end
      end
      CLEAR: begin
        if (req_cnt != 2'd0) error_next = 1'b1;
        if (clr_cnt_reg == LAST_IDX) begin
          state_next      = IDLE;
          clear_done_next = 1'b1;
          error_next      = 1'b0;
        end else begin
          clr_cnt_next = clr_cnt_reg + 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg      <= IDLE;
      clr_cnt_reg    <= '0;
      write_done_reg <= 1'b0;
      clear_done_reg <= 1'b0;
      error_reg      <= 1'b0;
    end else begin
      state_reg      <= state_next;
      clr_cnt_reg    <= clr_cnt_next;
      write_done_reg <= write_done_next;
      clear_done_reg <= clear_done_next;
      error_reg      <= error_next;
    end
  end

  // One memory per byte lane so each lane has its own write enable.
  genvar gi;
  generate
    for (gi = 0; gi < NBYTES; gi++) begin : g_lane
      logic [7:0] lane_mem [2**AW];

      always_ff @(posedge clk) begin
        if (state_reg == CLEAR) begin
          lane_mem[clr_idx] <= 8'h00;
        end else if (acc_write && write_mask[gi]) begin
          lane_mem[addr_idx] <= in[8*gi +: 8];
        end
      end

      assign rd_word[8*gi +: 8] = lane_mem[addr_idx];
    end
  endgenerate

  assign rd_data = in_range ? rd_word : '0;

  seq_mem_rd_pipe #(
    .WIDTH   (WIDTH),
    .LATENCY (READ_LATENCY)
  ) u_rd_pipe (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (acc_read),
    .in_data   (rd_data),
    .out_valid (read_done),
    .out_data  (out)
  );

  assign write_done = write_done_reg;
  assign clear_done = clear_done_reg;
  assign error      = error_reg;
  assign busy       = (state_reg == CLEAR);

endmodule

// File: tb/tb_seq_mem_pipe.sv
// Directed bench: dut_a (LAT=1, IDX_SIZE=5 for out-of-range addresses) and
// dut_b (LAT=3) driven by per-feature tasks with hand-computed expectations.
module tb_seq_mem_pipe;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset_n;

  logic [4:0]  a_addr;
  logic        a_read_en, a_write_en, a_clear_en;
  logic [31:0] a_in, a_out;
  logic [3:0]  a_mask;
  logic        a_read_done, a_write_done, a_busy, a_clear_done, a_error;

  logic [3:0]  b_addr;
  logic        b_read_en, b_write_en, b_clear_en;
  logic [31:0] b_in, b_out;
  logic [3:0]  b_mask;
  logic        b_read_done, b_write_done, b_busy, b_clear_done, b_error;

  seq_mem_pipe #(.WIDTH(32), .SIZE(16), .IDX_SIZE(5), .READ_LATENCY(1)) dut_a (
    .clk(clk), .reset(reset_n), .addr0(a_addr), .read_en(a_read_en), .out(a_out),
    .read_done(a_read_done), .in(a_in), .write_en(a_write_en), .write_mask(a_mask),
    .write_done(a_write_done), .clear_en(a_clear_en), .busy(a_busy),
    .clear_done(a_clear_done), .error(a_error)
  );

  seq_mem_pipe #(.WIDTH(32), .SIZE(16), .IDX_SIZE(4), .READ_LATENCY(3)) dut_b (
    .clk(clk), .reset(reset_n), .addr0(b_addr), .read_en(b_read_en), .out(b_out),
    .read_done(b_read_done), .in(b_in), .write_en(b_write_en), .write_mask(b_mask),
    .write_done(b_write_done), .clear_en(b_clear_en), .busy(b_busy),
    .clear_done(b_clear_done), .error(b_error)
  );

  int pass_cnt  = 0;
  int total_cnt = 0;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic write_a(input logic [4:0] addr, input logic [31:0] data,
                         input logic [3:0] mask, input string name);
    $display("write a addr=%0d data=%h mask=%h", addr, data, mask);
    a_addr = addr; a_in = data; a_mask = mask; a_write_en = 1'b1;
    step();
    a_write_en = 1'b0;
    total_cnt++;
    if (a_write_done !== 1'b1) $display("FAIL %s write_done: got %b want 1", name, a_write_done);
    else pass_cnt++;
    step();
    total_cnt++;
    if (a_write_done !== 1'b0) $display("FAIL %s write_done_fall: got %b want 0", name, a_write_done);
    else pass_cnt++;
  endtask

  task automatic read_a(input logic [4:0] addr, input logic [31:0] exp, input string name);
    $display("read a addr=%0d expect=%h", addr, exp);
    a_addr = addr; a_read_en = 1'b1;
    step();
    a_read_en = 1'b0;
    total_cnt++;
    if (a_read_done !== 1'b1) $display("FAIL %s read_done: got %b want 1", name, a_read_done);
    else pass_cnt++;
    total_cnt++;
    if (a_out !== exp) $display("FAIL %s out: got %h want %h", name, a_out, exp);
    else pass_cnt++;
    step();
    total_cnt++;
    if (a_read_done !== 1'b0) $display("FAIL %s read_done_fall: got %b want 0", name, a_read_done);
    else pass_cnt++;
    total_cnt++;
    if (a_out !== exp) $display("FAIL %s out_hold: got %h want %h", name, a_out, exp);
    else pass_cnt++;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    total_cnt++;
    if ({a_out, a_read_done, a_write_done, a_busy, a_clear_done, a_error} !== 37'd0)
      $display("FAIL reset_a outputs: got out=%h rd=%b wd=%b busy=%b cd=%b err=%b want all 0",
               a_out, a_read_done, a_write_done, a_busy, a_clear_done, a_error);
    else pass_cnt++;
    total_cnt++;
    if ({b_out, b_read_done, b_write_done, b_busy, b_clear_done, b_error} !== 37'd0)
      $display("FAIL reset_b outputs: got out=%h rd=%b wd=%b busy=%b cd=%b err=%b want all 0",
               b_out, b_read_done, b_write_done, b_busy, b_clear_done, b_error);
    else pass_cnt++;
    reset_n = 1'b1;
  endtask

  task automatic test_write_read();
    write_a(5'd3, 32'hDEADBEEF, 4'hF, "wr_full");
    read_a(5'd3, 32'hDEADBEEF, "rd_full");
    total_cnt++;
    if (a_error !== 1'b0) $display("FAIL wr_rd error: got %b want 0", a_error);
    else pass_cnt++;
  endtask

  task automatic test_mask();
    write_a(5'd5, 32'h11223344, 4'hF, "mask_base");
    write_a(5'd5, 32'h0000AA00, 4'h2, "mask_byte1");
    read_a(5'd5, 32'h1122AA44, "mask_read");
  endtask

  task automatic test_conflict();
    $display("conflict a read+write addr=3");
    a_addr = 5'd3; a_in = 32'h0; a_mask = 4'hF; a_read_en = 1'b1; a_write_en = 1'b1;
    step();
    a_read_en = 1'b0; a_write_en = 1'b0;
    total_cnt++;
    if (a_read_done !== 1'b0 || a_write_done !== 1'b0)
      $display("FAIL conflict dones: got rd=%b wd=%b want 0 0", a_read_done, a_write_done);
    else pass_cnt++;
    total_cnt++;
    if (a_error !== 1'b1) $display("FAIL conflict error: got %b want 1", a_error);
    else pass_cnt++;
    step();
    total_cnt++;
    if (a_read_done !== 1'b0) $display("FAIL conflict late read_done: got %b want 0", a_read_done);
    else pass_cnt++;
    read_a(5'd3, 32'hDEADBEEF, "conflict_unchanged");
    total_cnt++;
    if (a_error !== 1'b1) $display("FAIL conflict sticky error: got %b want 1", a_error);
    else pass_cnt++;
  endtask

  task automatic run_clear(input bit inject, input string name);
    int  busy_cnt = 0;
    int  rd_seen  = 0;
    bit  done_seen = 1'b0;
    logic err_mid = 1'b0;
    $display("clear a inject=%0d", inject);
    a_clear_en = 1'b1;
    step();
    a_clear_en = 1'b0;
    total_cnt++;
    if (a_busy !== 1'b1) $display("FAIL %s busy_enter: got %b want 1", name, a_busy);
    else pass_cnt++;
    for (int k = 0; k < 40 && !done_seen; k++) begin
      if (a_busy) busy_cnt++;
      if (a_read_done) rd_seen++;
      if (a_clear_done) done_seen = 1'b1;
      else begin
        if (inject && k == 3) begin a_addr = 5'd1; a_read_en = 1'b1; end
        step();
        a_read_en = 1'b0;
        if (inject && k == 3) err_mid = a_error;
      end
    end
    total_cnt++;
    if (done_seen !== 1'b1) $display("FAIL %s clear_done: got %b want 1 within 40 cycles", name, done_seen);
    else pass_cnt++;
    total_cnt++;
    if (busy_cnt != 16) $display("FAIL %s busy_cycles: got %0d want 16", name, busy_cnt);
    else pass_cnt++;
    total_cnt++;
    if (rd_seen != 0) $display("FAIL %s read_done_in_sweep: got %0d want 0", name, rd_seen);
    else pass_cnt++;
    total_cnt++;
    if (a_busy !== 1'b0 || a_error !== 1'b0)
      $display("FAIL %s end_state: got busy=%b err=%b want 0 0", name, a_busy, a_error);
    else pass_cnt++;
    if (inject) begin
      total_cnt++;
      if (err_mid !== 1'b1) $display("FAIL %s error_mid_sweep: got %b want 1", name, err_mid);
      else pass_cnt++;
    end
    step();
    total_cnt++;
    if (a_clear_done !== 1'b0) $display("FAIL %s clear_done_fall: got %b want 0", name, a_clear_done);
    else pass_cnt++;
  endtask

  task automatic test_clear();
    run_clear(1'b0, "clear1");
    for (int i = 0; i < 16; i++) read_a(5'(i), 32'h0, "clear_zero");
    run_clear(1'b1, "clear2");
  endtask

  task automatic test_out_of_range();
    write_a(5'd2, 32'h12345678, 4'hF, "oor_setup");
    read_a(5'd2, 32'h12345678, "oor_setup_rd");
    total_cnt++;
    if (a_error !== 1'b0) $display("FAIL oor pre error: got %b want 0", a_error);
    else pass_cnt++;
    read_a(5'd20, 32'h0, "oor_read");
    total_cnt++;
    if (a_error !== 1'b1) $display("FAIL oor read error: got %b want 1", a_error);
    else pass_cnt++;
    write_a(5'd20, 32'hCAFEF00D, 4'hF, "oor_write");
    read_a(5'd4, 32'h0, "oor_no_alias");
  endtask

  task automatic test_reset_mid_clear();
    read_a(5'd2, 32'h12345678, "midrst_setup");
    a_clear_en = 1'b1;
    step();
    a_clear_en = 1'b0;
    a_write_en = 1'b1; a_addr = 5'd6; a_in = 32'h1; a_mask = 4'hF;
    step();
    a_write_en = 1'b0;
    step();
    total_cnt++;
    if (a_busy !== 1'b1 || a_error !== 1'b1)
      $display("FAIL midrst pre: got busy=%b err=%b want 1 1", a_busy, a_error);
    else pass_cnt++;
    #2 reset_n = 1'b0;
    #1;
    total_cnt++;
    if ({a_out, a_read_done, a_write_done, a_busy, a_clear_done, a_error} !== 37'd0)
      $display("FAIL midrst outputs: got out=%h rd=%b wd=%b busy=%b cd=%b err=%b want all 0",
               a_out, a_read_done, a_write_done, a_busy, a_clear_done, a_error);
    else pass_cnt++;
    step();
    reset_n = 1'b1;
    write_a(5'd1, 32'hA5A55A5A, 4'hF, "post_reset_wr");
    read_a(5'd1, 32'hA5A55A5A, "post_reset_rd");
  endtask

  task automatic test_pipelined();
    logic [31:0] exp_q [3];
    logic        exp_done;
    exp_q[0] = 32'hA0A00000; exp_q[1] = 32'hB1B11111; exp_q[2] = 32'hC2C22222;
    for (int i = 0; i < 3; i++) begin
      $display("write b addr=%0d data=%h", i, exp_q[i]);
      b_addr = 4'(i); b_in = exp_q[i]; b_mask = 4'hF; b_write_en = 1'b1;
      step();
      b_write_en = 1'b0;
      total_cnt++;
      if (b_write_done !== 1'b1) $display("FAIL pipe write_done: got %b want 1", b_write_done);
      else pass_cnt++;
    end
    for (int k = 0; k < 7; k++) begin
      if (k < 3) begin
        $display("read b addr=%0d", k);
        b_addr = 4'(k); b_read_en = 1'b1;
      end else if (k == 3) begin
        $display("write b addr=2 data=5555aaaa (in flight)");
        b_addr = 4'd2; b_in = 32'h5555AAAA; b_write_en = 1'b1;
      end
      step();
      b_read_en = 1'b0; b_write_en = 1'b0;
      exp_done = (k >= 2 && k <= 4);
      total_cnt++;
      if (b_read_done !== exp_done)
        $display("FAIL pipe read_done k=%0d: got %b want %b", k, b_read_done, exp_done);
      else pass_cnt++;
      if (exp_done) begin
        total_cnt++;
        if (b_out !== exp_q[k-2]) $display("FAIL pipe data k=%0d: got %h want %h", k, b_out, exp_q[k-2]);
        else pass_cnt++;
      end else if (k > 4) begin
        total_cnt++;
        if (b_out !== exp_q[2]) $display("FAIL pipe hold k=%0d: got %h want %h", k, b_out, exp_q[2]);
        else pass_cnt++;
      end
    end
    $display("read b addr=2 after in-flight write");
    b_addr = 4'd2; b_read_en = 1'b1;
    step();
    b_read_en = 1'b0;
    step();
    total_cnt++;
    if (b_read_done !== 1'b0) $display("FAIL pipe early done: got %b want 0", b_read_done);
    else pass_cnt++;
    step();
    total_cnt++;
    if (b_read_done !== 1'b1 || b_out !== 32'h5555AAAA)
      $display("FAIL pipe reread: got done=%b out=%h want 1 5555aaaa", b_read_done, b_out);
    else pass_cnt++;
  endtask

  initial begin
    reset_n = 1'b0;
    a_addr = '0; a_read_en = 1'b0; a_write_en = 1'b0; a_clear_en = 1'b0; a_in = '0; a_mask = '0;
    b_addr = '0; b_read_en = 1'b0; b_write_en = 1'b0; b_clear_en = 1'b0; b_in = '0; b_mask = '0;
    test_reset();
    test_write_read();
    test_mask();
    test_conflict();
    test_clear();
    test_out_of_range();
    test_pipelined();
    test_reset_mid_clear();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
